// File: rtl/spike_rate_decoder.sv
// Spike-rate readout: counts spikes over a programmable window and hands the count off
// through valid/ready. It also reports each inter-spike interval as a one-cycle pulse.
module spike_rate_decoder #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spike,
   input  logic             enable,
   input  logic [CNT_W-1:0] window_len,
   output logic [CNT_W-1:0] rate,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic [CNT_W-1:0] isi,
   output logic             isi_valid,
   output logic             overrun
);

   typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_pos;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_gap;
   logic             r_seen;
   logic [CNT_W-1:0] r_rate;
   logic             r_rate_valid;
   logic [CNT_W-1:0] r_isi;
   logic             r_isi_valid;
   logic             r_overrun;

   state_t           w_state_nx;
   logic [CNT_W-1:0] w_pos_nx;
   logic [CNT_W-1:0] w_len_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic [CNT_W-1:0] w_gap_nx;
   logic             w_seen_nx;
   logic [CNT_W-1:0] w_rate_nx;
   logic             w_rate_valid_nx;
   logic [CNT_W-1:0] w_isi_nx;
   logic             w_isi_valid_nx;
   logic             w_overrun_nx;

   logic             w_first;
   logic [CNT_W-1:0] w_len;
   logic             w_last;
   logic [CNT_W-1:0] w_base;
   logic [CNT_W-1:0] w_sum;
   logic             w_xfer;
   logic [CNT_W-1:0] w_gap_inc;

   // A zero window length wraps len-1 to all ones, giving 2^CNT_W cycles.
   assign w_first   = (r_state == IDLE) || (r_pos == '0);
   assign w_len     = w_first ? window_len : r_len;
   assign w_last    = (r_pos == (w_len - ONE));
   assign w_base    = w_first ? '0 : r_cnt;
   assign w_sum     = (spike && (w_base != MAX)) ? (w_base + ONE) : w_base;
   assign w_xfer    = r_rate_valid && rate_ready;
   assign w_gap_inc = (r_gap != MAX) ? (r_gap + ONE) : r_gap;

   always_comb begin
      w_state_nx      = enable ? COUNT : IDLE;
      w_pos_nx        = r_pos;
      w_len_nx        = r_len;
      w_cnt_nx        = r_cnt;
      w_gap_nx        = r_gap;
      w_seen_nx       = r_seen;
      w_rate_nx       = r_rate;
      w_rate_valid_nx = r_rate_valid;
      w_isi_nx        = r_isi;
      w_isi_valid_nx  = 1'b0;
      w_overrun_nx    = r_overrun;

      if (w_xfer) begin
         w_rate_valid_nx = 1'b0;
      end

      if (!enable) begin
         w_pos_nx  = '0;
         w_cnt_nx  = '0;
         w_gap_nx  = '0;
         w_seen_nx = 1'b0;
      end else begin
         w_len_nx = w_len;
         if (w_last) begin
            w_pos_nx = '0;
            w_cnt_nx = '0;
            if (!r_rate_valid || w_xfer) begin
               w_rate_nx       = w_sum;
               w_rate_valid_nx = 1'b1;
            end else begin
               w_overrun_nx = 1'b1;
            end
         end else begin
            w_pos_nx = r_pos + ONE;
            w_cnt_nx = w_sum;
         end

         if (spike) begin
            if (r_seen) begin
               w_isi_nx       = w_gap_inc;
               w_isi_valid_nx = 1'b1;
            end
            w_seen_nx = 1'b1;
            w_gap_nx  = '0;
         end else begin
            w_gap_nx = w_gap_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pos        <= '0;
         r_len        <= '0;
         r_cnt        <= '0;
         r_gap        <= '0;
         r_seen       <= 1'b0;
         r_rate       <= '0;
         r_rate_valid <= 1'b0;
         r_isi        <= '0;
         r_isi_valid  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_pos        <= w_pos_nx;
         r_len        <= w_len_nx;
         r_cnt        <= w_cnt_nx;
         r_gap        <= w_gap_nx;
         r_seen       <= w_seen_nx;
         r_rate       <= w_rate_nx;
         r_rate_valid <= w_rate_valid_nx;
         r_isi        <= w_isi_nx;
         r_isi_valid  <= w_isi_valid_nx;
         r_overrun    <= w_overrun_nx;
      end
   end

   assign rate       = r_rate;
   assign rate_valid = r_rate_valid;
   assign isi        = r_isi;
   assign isi_valid  = r_isi_valid;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: rate windows, handshake, overrun, ISI, abort and reset.
module tb_spike_rate_decoder;

   logic       clk;
   logic       rst_n;
   logic       spike;
   logic       enable;
   logic [7:0] window_len;
   logic [7:0] rate;
   logic       rate_valid;
   logic       rate_ready;
   logic [7:0] isi;
   logic       isi_valid;
   logic       overrun;

   int n_checks;
   int n_fail;

   spike_rate_decoder #(.CNT_W(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike      (spike),
      .enable     (enable),
      .window_len (window_len),
      .rate       (rate),
      .rate_valid (rate_valid),
      .rate_ready (rate_ready),
      .isi        (isi),
      .isi_valid  (isi_valid),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Drive spike for the next rising edge, then sample 1 time unit after it.
   task automatic step(input logic s);
      spike = s;
      @(posedge clk);
      #1;
   endtask

   task automatic abort_step();
      enable     = 1'b0;
      rate_ready = 1'b1;
      step(1'b0);
   endtask

   logic [9:0] pat_basic;
   logic [9:0] pat_ovr;

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      spike      = 1'b0;
      enable     = 1'b0;
      window_len = 8'd0;
      rate_ready = 1'b0;
      pat_basic  = 10'b0010001001;
      pat_ovr    = 10'b0111100011;

      #12;
      check_eq("rst_rate", rate, 0);
      check_eq("rst_valid", rate_valid, 0);
      check_eq("rst_isi", isi, 0);
      check_eq("rst_isi_valid", isi_valid, 0);
      check_eq("rst_overrun", overrun, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic rate: N=10, spikes at edges 0,3,7.
      window_len = 8'd10;
      rate_ready = 1'b1;
      enable     = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step(pat_basic[e]);
         if (e == 3) begin
            check_eq("basic_isi_valid_e3", isi_valid, 1);
            check_eq("basic_isi_e3", isi, 3);
         end
         if (e == 7) check_eq("basic_isi_e7", isi, 4);
         if (e == 8) check_eq("basic_valid_e8", rate_valid, 0);
      end
      check_eq("basic_valid_e9", rate_valid, 1);
      check_eq("basic_rate_e9", rate, 3);
      step(1'b0);
      check_eq("basic_valid_e10", rate_valid, 0);
      abort_step();

      // Back-to-back windows, N=4, spike every cycle.
      window_len = 8'd4;
      enable     = 1'b1;
      for (int e = 0; e < 12; e++) begin
         step(1'b1);
         if (e == 0) check_eq("b2b_isi_first", isi_valid, 0);
         if (e == 1) begin
            check_eq("b2b_isi_valid", isi_valid, 1);
            check_eq("b2b_isi", isi, 1);
         end
         if ((e % 4) == 3) begin
            check_eq("b2b_valid_end", rate_valid, 1);
            check_eq("b2b_rate_end", rate, 4);
         end
         if (e == 4 || e == 8) check_eq("b2b_valid_mid", rate_valid, 0);
      end
      abort_step();
      check_eq("b2b_valid_after", rate_valid, 0);

      // Full scale: N=0 means 256 cycles, all spikes, count saturates.
      window_len = 8'd0;
      enable     = 1'b1;
      for (int e = 0; e < 256; e++) begin
         step(1'b1);
         if (e == 254) check_eq("full_valid_e254", rate_valid, 0);
      end
      check_eq("full_valid_e255", rate_valid, 1);
      check_eq("full_rate_e255", rate, 255);
      abort_step();

      // Overrun: N=5, ready low, windows of 2 then 4 spikes.
      window_len = 8'd5;
      rate_ready = 1'b0;
      enable     = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step(pat_ovr[e]);
         if (e == 4) begin
            check_eq("ovr_valid_e4", rate_valid, 1);
            check_eq("ovr_rate_e4", rate, 2);
            check_eq("ovr_flag_e4", overrun, 0);
         end
         if (e == 8) check_eq("ovr_flag_e8", overrun, 0);
      end
      check_eq("ovr_rate_held", rate, 2);
      check_eq("ovr_valid_held", rate_valid, 1);
      check_eq("ovr_flag_set", overrun, 1);
      abort_step();
      check_eq("ovr_valid_xfer", rate_valid, 0);
      check_eq("ovr_flag_sticky", overrun, 1);

      rst_n = 1'b0;
      #2;
      check_eq("ovr_flag_reset", overrun, 0);
      rst_n = 1'b1;

      // Transfer on the same edge as the next window's end: N=3.
      window_len = 8'd3;
      rate_ready = 1'b0;
      enable     = 1'b1;
      step(1'b1);
      step(1'b0);
      step(1'b0);
      check_eq("xend_valid_w1", rate_valid, 1);
      check_eq("xend_rate_w1", rate, 1);
      step(1'b1);
      step(1'b1);
      check_eq("xend_rate_stable", rate, 1);
      rate_ready = 1'b1;
      step(1'b0);
      check_eq("xend_valid_w2", rate_valid, 1);
      check_eq("xend_rate_w2", rate, 2);
      check_eq("xend_overrun", overrun, 0);
      abort_step();

      // ISI: spikes at 2, 3, 9, silence for 300 edges, then one spike.
      window_len = 8'd0;
      enable     = 1'b1;
      for (int e = 0; e <= 310; e++) begin
         step((e == 2) || (e == 3) || (e == 9) || (e == 310));
         if (e == 2) check_eq("isi_first_nopulse", isi_valid, 0);
         if (e == 3) begin
            check_eq("isi_valid_e3", isi_valid, 1);
            check_eq("isi_e3", isi, 1);
         end
         if (e == 4) begin
            check_eq("isi_pulse_width", isi_valid, 0);
            check_eq("isi_hold", isi, 1);
         end
         if (e == 9) begin
            check_eq("isi_valid_e9", isi_valid, 1);
            check_eq("isi_e9", isi, 6);
         end
      end
      check_eq("isi_valid_sat", isi_valid, 1);
      check_eq("isi_sat", isi, 255);
      abort_step();

      // Abort mid-window after two spikes: no result may appear.
      window_len = 8'd10;
      enable     = 1'b1;
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);
      enable = 1'b0;
      for (int e = 0; e < 10; e++) begin
         step(1'b0);
         check_eq("abort_no_result", rate_valid, 0);
      end

      // Re-enable: first spike after abort must not pulse.
      enable = 1'b1;
      for (int e = 0; e < 4; e++) begin
         step(e == 0);
         check_eq("abort_isi_cleared", isi_valid, 0);
      end
      abort_step();

      // Async reset mid-window with a pending result and overrun set.
      window_len = 8'd2;
      rate_ready = 1'b0;
      enable     = 1'b1;
      for (int e = 0; e < 5; e++) begin
         step(1'b1);
         if (e == 1) begin
            check_eq("arst_pre_valid", rate_valid, 1);
            check_eq("arst_pre_rate", rate, 2);
         end
         if (e == 3) check_eq("arst_pre_overrun", overrun, 1);
      end
      check_eq("arst_pre_isi_valid", isi_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_rate", rate, 0);
      check_eq("arst_valid", rate_valid, 0);
      check_eq("arst_isi", isi, 0);
      check_eq("arst_isi_valid", isi_valid, 0);
      check_eq("arst_overrun", overrun, 0);
      enable = 1'b0;
      #10;
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
